// File: rtl/lifo_drain_ctrl.sv
// Drains a snapshot of the lifo contents into a valid/ready packet stream.
// A 2-entry skid buffer hides the lifo read latency so ready=1 gives 1 word/cycle.
module lifo_drain_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              start_i,
  input  logic              lifo_empty_i,
  input  logic [AWIDTH:0]   lifo_usedw_i,
  input  logic [DWIDTH-1:0] lifo_q_i,
  output logic              lifo_rdreq_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  output logic              src_last_o,
  input  logic              src_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [AWIDTH:0]   word_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [AWIDTH:0] CNT_ZERO = {(AWIDTH+1){1'b0}};
  localparam logic [AWIDTH:0] CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic [AWIDTH:0]   len_r, len_s;
  logic [AWIDTH:0]   pops_left_r, pops_left_s;
  logic [AWIDTH:0]   word_cnt_r, word_cnt_s;
  logic [1:0]        occ_r, occ_s;
  logic              inflight_r;
  logic [DWIDTH-1:0] buf0_r, buf0_s;
  logic [DWIDTH-1:0] buf1_r, buf1_s;
  logic              valid_r, last_r, busy_r, done_r;
  logic              pop_s, rdreq_s, done_s, last_s;
  logic [2:0]        room_s;

  // Next-state, pop decision and skid-buffer update
  always_comb begin
    state_s     = state_r;
    len_s       = len_r;
    pops_left_s = pops_left_r;
    rdreq_s     = 1'b0;
    done_s      = 1'b0;
    buf0_s      = buf0_r;
    buf1_s      = buf1_r;
    occ_s       = occ_r;
    pop_s       = valid_r & src_ready_i;
    // entries the buffer must still hold after this edge, counting the word in flight
    room_s      = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    word_cnt_s  = pop_s ? (word_cnt_r + CNT_ONE) : word_cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (start_i && (lifo_usedw_i != CNT_ZERO)) begin
          len_s       = lifo_usedw_i;
          pops_left_s = lifo_usedw_i;
          word_cnt_s  = CNT_ZERO;
          state_s     = ST_DRAIN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if ((pops_left_r != CNT_ZERO) && !lifo_empty_i && (room_s < 3'd2)) begin
          rdreq_s     = 1'b1;
          pops_left_s = pops_left_r - CNT_ONE;
          if (pops_left_r == CNT_ONE) begin
            state_s = ST_FLUSH;
          end else begin
            state_s = ST_DRAIN;
          end
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        if (pop_s && last_r) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    case ({inflight_r, pop_s})
      2'b01: begin
        buf0_s = buf1_r;
        occ_s  = occ_r - 2'd1;
      end
      2'b10: begin
        if (occ_r == 2'd0) begin
          buf0_s = lifo_q_i;
        end else begin
          buf1_s = lifo_q_i;
        end
        occ_s = occ_r + 2'd1;
      end
      2'b11: begin
        if (occ_r == 2'd2) begin
          buf0_s = buf1_r;
          buf1_s = lifo_q_i;
        end else begin
          buf0_s = lifo_q_i;
        end
      end
      default: begin
        occ_s = occ_r;
      end
    endcase

    last_s = (occ_s != 2'd0) && ((word_cnt_s + CNT_ONE) == len_s);
  end

  // State, buffer and registered stream outputs
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_r     <= ST_IDLE;
      len_r       <= CNT_ZERO;
      pops_left_r <= CNT_ZERO;
      word_cnt_r  <= CNT_ZERO;
      occ_r       <= 2'd0;
      inflight_r  <= 1'b0;
      buf0_r      <= {DWIDTH{1'b0}};
      buf1_r      <= {DWIDTH{1'b0}};
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      pops_left_r <= pops_left_s;
      word_cnt_r  <= word_cnt_s;
      occ_r       <= occ_s;
      inflight_r  <= rdreq_s;
      buf0_r      <= buf0_s;
      buf1_r      <= buf1_s;
      valid_r     <= (occ_s != 2'd0);
      last_r      <= last_s;
      busy_r      <= (state_s != ST_IDLE);
      done_r      <= done_s;
    end
  end

  assign lifo_rdreq_o = rdreq_s;
  assign src_data_o   = buf0_r;
  assign src_valid_o  = valid_r;
  assign src_last_o   = last_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign word_cnt_o   = word_cnt_r;

endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// Directed bench for lifo_drain_ctrl with a behavioural lifo model feeding it.
module tb_lifo_drain_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          start = 1'b0;
  logic          lifo_empty;
  logic [AW:0]   lifo_usedw;
  logic [DW-1:0] lifo_q;
  logic          lifo_rdreq;
  logic [DW-1:0] data;
  logic          valid, last;
  logic          ready = 1'b0;
  logic          busy, done;
  logic [AW:0]   word_cnt;

  always #5 clk = ~clk;

  lifo_drain_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i(clk), .srst_i(srst), .start_i(start),
    .lifo_empty_i(lifo_empty), .lifo_usedw_i(lifo_usedw), .lifo_q_i(lifo_q),
    .lifo_rdreq_o(lifo_rdreq), .src_data_o(data), .src_valid_o(valid),
    .src_last_o(last), .src_ready_i(ready), .busy_o(busy), .done_o(done),
    .word_cnt_o(word_cnt)
  );

  // lifo model: write port driven by the bench, read port by the DUT
  logic [DW-1:0] mem [0:15];
  logic [AW:0]   cnt = '0;
  logic [DW-1:0] q = '0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  always @(posedge clk) begin
    if (wr_en) begin
      mem[cnt[AW-1:0]] <= wr_data;
      cnt <= cnt + 5'd1;
    end else if (lifo_rdreq && cnt != 5'd0) begin
      q   <= mem[cnt[AW-1:0] - 4'd1];
      cnt <= cnt - 5'd1;
    end
  end

  assign lifo_empty = (cnt == 5'd0);
  assign lifo_usedw = cnt;
  assign lifo_q     = q;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] rx [0:15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_words(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = base + DW'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_rdreq", 32'(lifo_rdreq), 32'd0);
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
  endtask

  // mode 0: ready=1, 1: random ready, 2: ready=0 for the first 10 cycles
  task automatic run_packet(input int n, input int mode, input int restart_at);
    logic [DW-1:0] exp_w [0:15];
    int got = 0;
    int first_valid = -1;
    int stall_rd = 0;
    logic hold = 1'b0;
    logic [DW-1:0] hd = '0;
    logic hl = 1'b0;
    logic finished = 1'b0;
    for (int k = 0; k < n; k++) exp_w[k] = mem[4'(n - 1 - k)];
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (hold) begin
        chk("hold_valid", 32'(valid), 32'd1);
        chk("hold_data", 32'(data), 32'(hd));
        chk("hold_last", 32'(last), 32'(hl));
      end
      case (mode)
        1:       ready = ($urandom_range(0, 2) != 0);
        2:       ready = (cyc >= 10);
        default: ready = 1'b1;
      endcase
      #1;
      if (lifo_rdreq) begin
        chk("rdreq_while_empty", 32'(lifo_empty), 32'd0);
        if (cyc < 10) stall_rd++;
      end
      if (got == n) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("word_cnt_end", 32'(word_cnt), 32'(n));
        finished = 1'b1;
      end else begin
        chk("busy_in_packet", 32'(busy), 32'd1);
        chk("no_early_done", 32'(done), 32'd0);
        if (valid && first_valid < 0) first_valid = cyc;
        if (mode == 0 && first_valid >= 0) chk("gapless_valid", 32'(valid), 32'd1);
        if (valid && ready) begin
          chk("data", 32'(data), 32'(exp_w[got]));
          chk("last", 32'(last), 32'(got == n - 1));
          rx[got] = data;
          got++;
        end
        hold = valid && !ready;
        hd   = data;
        hl   = last;
      end
    end
    chk("packet_complete", 32'(finished), 32'd1);
    if (mode == 0) chk("first_valid_cycle", 32'(first_valid), 32'd2);
    if (mode == 2) chk("stall_rdreq_count", 32'(stall_rd), 32'd2);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("word_cnt_hold", 32'(word_cnt), 32'(n));
  endtask

  initial begin
    int stall;
    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_rdreq", 32'(lifo_rdreq), 32'd0);
    srst = 1'b0;

    // 5 words A0..A4, ready=1: expect A4..A0
    load_words(5, 8'hA0);
    pulse_start();
    run_packet(5, 0, -1);
    chk("t1_word0", 32'(rx[0]), 32'h0000_00A4);
    chk("t1_word4", 32'(rx[4]), 32'h0000_00A0);
    chk("t1_empty", 32'(lifo_empty), 32'd1);

    // start with an empty lifo is ignored
    pulse_start();
    idle_check(5);

    // full lifo, random backpressure
    load_words(16, 8'h10);
    pulse_start();
    run_packet(16, 1, -1);
    chk("t3_word0", 32'(rx[0]), 32'h0000_001F);
    chk("t3_word15", 32'(rx[15]), 32'h0000_0010);
    chk("t3_empty", 32'(lifo_empty), 32'd1);

    // second start while busy is ignored
    load_words(3, 8'h30);
    pulse_start();
    run_packet(3, 0, 1);
    idle_check(4);

    // ready low for 10 cycles
    load_words(4, 8'h40);
    pulse_start();
    run_packet(4, 2, -1);
    chk("t5_word0", 32'(rx[0]), 32'h0000_0043);

    // srst in DRAIN after 2 of 6 words were popped
    load_words(6, 8'hB0);
    pulse_start();
    stall = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      ready = 1'b0;
      #1;
      if (lifo_rdreq) stall++;
    end
    chk("t6_pops_before_rst", 32'(stall), 32'd2);
    chk("t6_busy_before_rst", 32'(busy), 32'd1);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    #1;
    chk("t6_valid", 32'(valid), 32'd0);
    chk("t6_last", 32'(last), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_word_cnt", 32'(word_cnt), 32'd0);
    chk("t6_data", 32'(data), 32'd0);
    chk("t6_rdreq", 32'(lifo_rdreq), 32'd0);
    chk("t6_usedw", 32'(lifo_usedw), 32'd4);
    pulse_start();
    run_packet(4, 0, -1);
    chk("t6_word0", 32'(rx[0]), 32'h0000_00B3);
    chk("t6_word3", 32'(rx[3]), 32'h0000_00B0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
